memref_stream_drain: RTL and testbench

//  Downstream stage of the HLS convolution kernel. On a start pulse it reads the

---
 rtl/memref_stream_drain.sv | 125 ++++++++++++
 tb/tb_memref_stream_drain.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/memref_stream_drain.sv
// Drains SIZE words from a 1-cycle-latency memref read port into a valid/ready stream.
// Optional clear-on-read write port enabled by defining MEMREF_DRAIN_CLEAR_EN.
module memref_stream_drain #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 8,
  parameter int SIZE   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tstart,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [WIDTH-1:0]  mem_rd_data,
`ifdef MEMREF_DRAIN_CLEAR_EN
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic              mem_wr_en,
  output logic [WIDTH-1:0]  mem_wr_data,
`endif
  output logic              m_valid,
  input  logic              m_ready,
  output logic [WIDTH-1:0]  m_data,
  output logic              m_last
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SIZE - 1);

  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] inflight_addr;
  logic              inflight;
  logic [WIDTH-1:0]  buf_data [2];
  logic [1:0]        buf_last;
  logic              head, tail;
  logic [1:0]        count;
  logic              pop, push, issue, accept, finish;
  logic [2:0]        level;

  assign pop   = m_valid & m_ready;
  assign push  = inflight;
  // Occupancy the buffer will have once this cycle's pop and in-flight return settle.
  assign level = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    accept   = 1'b0;
    finish   = 1'b0;
    case (state)
      IDLE: begin
        if (tstart && !done) begin
          accept   = 1'b1;
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (level < 3'd2) begin
          issue = 1'b1;
          if (rd_ptr == LAST_ADDR) state_nx = FLUSH;
        end
      end
      FLUSH: begin
        if (!inflight && count == 2'd1 && pop) begin
          finish   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done          <= 1'b0;
      rd_ptr        <= '0;
      addr_q        <= '0;
      inflight_addr <= '0;
      inflight      <= 1'b0;
      buf_last      <= '0;
      head          <= 1'b0;
      tail          <= 1'b0;
      count         <= '0;
      for (int unsigned i = 0; i < 2; i++) buf_data[i] <= '0;
    end else begin
      done     <= finish;
      inflight <= issue;
      if (accept) rd_ptr <= '0;
      if (issue) begin
        inflight_addr <= rd_ptr;
        addr_q        <= rd_ptr;
        if (rd_ptr != LAST_ADDR) rd_ptr <= rd_ptr + 1'b1;
      end
      if (push) begin
        buf_data[tail] <= mem_rd_data;
        buf_last[tail] <= (inflight_addr == LAST_ADDR);
        tail           <= ~tail;
      end
      if (pop) head <= ~head;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign busy      = (state != IDLE);
  assign mem_rd_en = issue;
  assign mem_addr  = issue ? rd_ptr : addr_q;
  assign m_valid   = (count != 2'd0);
  assign m_data    = m_valid ? buf_data[head] : '0;
  assign m_last    = m_valid & buf_last[head];

`ifdef MEMREF_DRAIN_CLEAR_EN
  assign mem_wr_en   = inflight;
  assign mem_wr_addr = inflight_addr;
  assign mem_wr_data = '0;
`endif

endmodule

// File: tb/tb_memref_stream_drain.sv
// Directed bench for memref_stream_drain (SIZE=4 main instance, SIZE=1 second instance).
module tb_memref_stream_drain;
  localparam int W  = 32;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0, tstart = 1'b0, m_ready = 1'b0, reload = 1'b0;
  logic          busy, done, mem_rd_en, m_valid, m_last;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  rd_data = '0, m_data;
  logic          tstart1 = 1'b0, ready1 = 1'b0;
  logic          busy1, done1, rd_en1, valid1, last1;
  logic [AW-1:0] addr1;
  logic [W-1:0]  rd_data1 = '0, data1;
`ifdef MEMREF_DRAIN_CLEAR_EN
  logic [AW-1:0] wr_addr, wr_addr1;
  logic          wr_en, wr_en1;
  logic [W-1:0]  wr_data, wr_data1;
`endif

  logic [W-1:0] mem [256];
  logic [W-1:0] beats [$];
  logic         lasts [$];
  logic [W:0]   beats1 [$];
  int           dones = 0, dones1 = 0;
  int           checks = 0, errors = 0;

  always #5 clk = ~clk;

  memref_stream_drain #(.WIDTH(W), .ADDR_W(AW), .SIZE(4)) dut (
    .clk(clk), .rst_n(rst_n), .tstart(tstart), .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rd_data(rd_data),
`ifdef MEMREF_DRAIN_CLEAR_EN
    .mem_wr_addr(wr_addr), .mem_wr_en(wr_en), .mem_wr_data(wr_data),
`endif
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last));

  memref_stream_drain #(.WIDTH(W), .ADDR_W(AW), .SIZE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .tstart(tstart1), .busy(busy1), .done(done1),
    .mem_addr(addr1), .mem_rd_en(rd_en1), .mem_rd_data(rd_data1),
`ifdef MEMREF_DRAIN_CLEAR_EN
    .mem_wr_addr(wr_addr1), .mem_wr_en(wr_en1), .mem_wr_data(wr_data1),
`endif
    .m_valid(valid1), .m_ready(ready1), .m_data(data1), .m_last(last1));

  always @(posedge clk) begin
    if (mem_rd_en) rd_data <= mem[mem_addr];
    if (rd_en1) rd_data1 <= (addr1 == '0) ? 32'd7 : 32'd0;
    if (reload) begin
      for (int i = 0; i < 4; i++) mem[i] <= 32'(10 * (i + 1));
    end
`ifdef MEMREF_DRAIN_CLEAR_EN
    else if (wr_en) mem[wr_addr] <= wr_data;
`endif
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle: drive inputs after the falling edge, sample outputs 1ns later.
  task automatic tick(input bit ts, input bit rdy, input bit rn, input bit ts1);
    @(negedge clk);
    tstart  = ts;
    m_ready = rdy;
    rst_n   = rn;
    tstart1 = ts1;
    ready1  = 1'($urandom_range(0, 1));
    #1;
    if (m_valid && m_ready) begin
      beats.push_back(m_data);
      lasts.push_back(m_last);
    end
    if (done) dones++;
    if (valid1 && ready1) beats1.push_back({last1, data1});
    if (done1) dones1++;
  endtask

  task automatic clear_log();
    beats.delete();
    lasts.delete();
    dones = 0;
  endtask

  task automatic reload_mem();
    reload = 1'b1;
    tick(0, 1, 1, 0);
    reload = 1'b0;
  endtask

  task automatic run_until_done(input string tag, input int budget);
    int n = 0;
    int d0 = dones;
    while (dones == d0 && n < budget) begin
      tick(0, 1, 1, 0);
      n++;
    end
    check({tag, "_done_seen"}, 32'(dones != d0), 32'd1);
  endtask

  task automatic check_seq(input string tag, input logic [31:0] scale);
    check({tag, "_beats"}, beats.size(), 32'd4);
    for (int i = 0; i < beats.size() && i < 4; i++) begin
      check($sformatf("%s_data%0d", tag, i), beats[i], scale * 32'(i + 1));
      check($sformatf("%s_last%0d", tag, i), 32'(lasts[i]), 32'(i == 3));
    end
  endtask

  initial begin
    int reads;
    reload = 1'b1;
    tick(0, 1, 0, 0);
    tick(0, 1, 0, 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_addr", 32'(mem_addr), 0);
    check("rst_rd_en", 32'(mem_rd_en), 0);
    check("rst_valid", 32'(m_valid), 0);
    check("rst_data", m_data, 0);
    check("rst_last", 32'(m_last), 0);
    reload = 1'b0;
    tick(0, 1, 1, 0);

    // Full-rate drain with exact cycle timing.
    clear_log();
    tick(1, 1, 1, 0);
    check("t1_busy_c0", 32'(busy), 0);
    for (int k = 1; k <= 8; k++) begin
      tick(0, 1, 1, 0);
      check($sformatf("t1_rd_en_c%0d", k), 32'(mem_rd_en), 32'(k >= 1 && k <= 4));
      if (k <= 4) check($sformatf("t1_addr_c%0d", k), 32'(mem_addr), 32'(k - 1));
      check($sformatf("t1_valid_c%0d", k), 32'(m_valid), 32'(k >= 3 && k <= 6));
      if (k >= 3 && k <= 6) check($sformatf("t1_data_c%0d", k), m_data, 32'(10 * (k - 2)));
      check($sformatf("t1_last_c%0d", k), 32'(m_last), 32'(k == 6));
      check($sformatf("t1_done_c%0d", k), 32'(done), 32'(k == 7));
      check($sformatf("t1_busy_c%0d", k), 32'(busy), 32'(k <= 6));
`ifdef MEMREF_DRAIN_CLEAR_EN
      check($sformatf("t6_wr_en_c%0d", k), 32'(wr_en), 32'(k >= 2 && k <= 5));
      if (k >= 2 && k <= 5) begin
        check($sformatf("t6_wr_addr_c%0d", k), 32'(wr_addr), 32'(k - 2));
        check($sformatf("t6_wr_data_c%0d", k), wr_data, 0);
      end
`endif
    end
    check_seq("t1", 32'd10);
    check("t1_dones", dones, 1);

`ifdef MEMREF_DRAIN_CLEAR_EN
    clear_log();
    tick(1, 1, 1, 0);
    run_until_done("t6", 20);
    check_seq("t6", 32'd0);
`endif

    // Backpressure: consumer stalls for cycles 0-9.
    reload_mem();
    clear_log();
    reads = 0;
    tick(1, 0, 1, 0);
    for (int k = 1; k <= 9; k++) begin
      tick(0, 0, 1, 0);
      reads += int'(mem_rd_en);
      if (k >= 3) begin
        check($sformatf("t2_valid_c%0d", k), 32'(m_valid), 1);
        check($sformatf("t2_hold_c%0d", k), m_data, 32'd10);
      end
    end
    check("t2_reads", reads, 2);
    run_until_done("t2", 30);
    check_seq("t2", 32'd10);

    // tstart during a drain and in the done cycle is ignored.
    reload_mem();
    clear_log();
    for (int k = 0; k <= 7; k++) tick(k == 0 || k == 4 || k == 7, 1, 1, 0);
    check_seq("t3", 32'd10);
    check("t3_dones", dones, 1);
    tick(0, 1, 1, 0);
    check("t3_idle_rd_en", 32'(mem_rd_en), 0);
    reload_mem();
    clear_log();
    tick(1, 1, 1, 0);
    tick(0, 1, 1, 0);
    check("t3_restart_rd_en", 32'(mem_rd_en), 1);
    check("t3_restart_addr", 32'(mem_addr), 0);
    run_until_done("t3b", 20);
    check_seq("t3b", 32'd10);

    // Reset mid-drain.
    reload_mem();
    clear_log();
    tick(1, 1, 1, 0);
    for (int k = 1; k <= 3; k++) tick(0, 1, 1, 0);
    tick(0, 1, 0, 0);
    tick(0, 1, 1, 0);
    check("t4_busy", 32'(busy), 0);
    check("t4_done", 32'(done), 0);
    check("t4_addr", 32'(mem_addr), 0);
    check("t4_rd_en", 32'(mem_rd_en), 0);
    check("t4_valid", 32'(m_valid), 0);
    check("t4_data", m_data, 0);
    check("t4_last", 32'(m_last), 0);
    for (int k = 0; k < 4; k++) tick(0, 1, 1, 0);
    check("t4_no_done", dones, 0);
    reload_mem();
    clear_log();
    tick(1, 1, 1, 0);
    run_until_done("t4b", 20);
    check_seq("t4b", 32'd10);
    check("t4b_dones", dones, 1);

    // SIZE=1 instance with random ready.
    beats1.delete();
    dones1 = 0;
    tick(0, 1, 1, 1);
    for (int k = 0; k < 40 && dones1 == 0; k++) tick(0, 1, 1, 0);
    check("t5_beats", beats1.size(), 1);
    if (beats1.size() > 0) begin
      check("t5_data", beats1[0][W-1:0], 32'd7);
      check("t5_last", 32'(beats1[0][W]), 1);
    end
    check("t5_dones", dones1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
